// File: rtl/interp_fir.sv
//==============================================================================
// Module      : interp_fir
// Description : Polyphase interpolating FIR filter. Each sample popped from
//               the upstream FIFO produces INTERPOLATION output samples, one
//               per polyphase branch. Each output uses one multiply-accumulate
//               per cycle over the TAPS/INTERPOLATION-deep delay line.
//               Optional build macro: INTERP_FIR_GAIN_EN scales each output
//               by INTERPOLATION. This compensates for the zero-stuffing gain
//               loss.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module interp_fir #(
    parameter int DATA_WIDTH    = 32,
    parameter int TAPS          = 32,
    parameter int INTERPOLATION = 8,
    parameter int BITS          = 10,
    parameter logic [0:TAPS-1][DATA_WIDTH-1:0] COEFF = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  x_empty,
    output logic                  x_rd_en,
    output logic [DATA_WIDTH-1:0] y_out,
    input  logic                  y_out_full,
    output logic                  y_wr_en
);

    // Polyphase geometry: M delay-line taps per output phase
    localparam int M     = TAPS / INTERPOLATION;
    localparam int PW    = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
    localparam int KW    = (M > 1) ? $clog2(M) : 1;
    localparam int CIW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int LOG2L = $clog2(INTERPOLATION);

    localparam logic [PW-1:0] c_P_LAST = PW'(INTERPOLATION - 1);
    localparam logic [KW-1:0] c_K_LAST = KW'(M - 1);

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_p;
    logic [KW-1:0]         r_k;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_x [0:M-1];

    logic [CIW-1:0]          w_cidx;
    logic [DATA_WIDTH-1:0]   w_coef;
    logic [DATA_WIDTH-1:0]   w_xk;
    logic [2*DATA_WIDTH-1:0] w_cext;
    logic [2*DATA_WIDTH-1:0] w_xext;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0]   w_term;
    logic [DATA_WIDTH-1:0]   w_yval;
    logic                    w_unused_shift;

    // Pop only when idle in S_READ with data available; never during reset
    always_comb begin
        x_rd_en = (r_state == S_READ) && !x_empty && !reset;
    end

    // Coefficient for tap k of phase p lives at k*L+p in the prototype filter.
    // Form the product at full double width, then shift and truncate it.
    always_comb begin
        w_cidx  = CIW'(r_k) * CIW'(INTERPOLATION) + CIW'(r_p);
        w_coef  = COEFF[w_cidx];
        w_xk    = r_x[r_k];
        w_cext  = {{DATA_WIDTH{w_coef[DATA_WIDTH-1]}}, w_coef};
        w_xext  = {{DATA_WIDTH{w_xk[DATA_WIDTH-1]}}, w_xk};
        w_prod  = $signed(w_cext) * $signed(w_xext);
        w_shift = $signed(w_prod) >>> BITS;
        w_term  = w_shift[DATA_WIDTH-1:0];
        w_unused_shift = &{1'b0, w_shift[2*DATA_WIDTH-1:DATA_WIDTH]};
    end

    // Output value: optional compensation for the 1/L zero-stuffing gain
    always_comb begin
`ifdef INTERP_FIR_GAIN_EN
        w_yval = r_sum << LOG2L;
`else
        w_yval = r_sum;
`endif
    end

    // Control FSM: read one sample, then MAC and write once per phase
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_READ;
            r_p     <= '0;
            r_k     <= '0;
            r_sum   <= '0;
            y_out   <= '0;
            y_wr_en <= 1'b0;
            for (int i = 0; i < M; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            y_wr_en <= 1'b0;
            case (r_state)
                S_READ: begin
                    if (x_rd_en) begin
                        r_x[0] <= x_in;
                        for (int i = M - 1; i > 0; i--) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_p     <= '0;
                        r_k     <= '0;
                        r_sum   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_sum <= r_sum + w_term;
                    if (r_k == c_K_LAST) begin
                        r_k     <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_WRITE: begin
                    // Downstream full: hold the finished sum until space opens
                    if (!y_out_full) begin
                        y_out   <= w_yval;
                        y_wr_en <= 1'b1;
                        if (r_p == c_P_LAST) begin
                            r_state <= S_READ;
                        end else begin
                            r_p     <= r_p + 1'b1;
                            r_k     <= '0;
                            r_sum   <= '0;
                            r_state <= S_MAC;
                        end
                    end
                end
                default: begin
                    r_state <= S_READ;
                    r_p     <= '0;
                    r_k     <= '0;
                    r_sum   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_interp_fir.sv
//==============================================================================
// Module      : tb_interp_fir
// Description : Randomized scoreboard bench for interp_fir. A FIFO model
//               feeds samples and predicts the outputs of every accepted
//               input. A separate monitor compares each written output with
//               the prediction.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_interp_fir;

    localparam int DW   = 32;
    localparam int TAPS = 32;
    localparam int L    = 8;
    localparam int BITS = 10;
    localparam int M    = TAPS / L;

    function automatic logic [0:TAPS-1][DW-1:0] gen_coeff();
        logic [0:TAPS-1][DW-1:0] r;
        for (int n = 0; n < TAPS; n++) begin
            r[n] = DW'(((n * 73 + 11) % 257 - 128) * 5);
        end
        return r;
    endfunction

    localparam logic [0:TAPS-1][DW-1:0] C = gen_coeff();

    logic          clk;
    logic          reset;
    logic [DW-1:0] x_in;
    logic          x_empty;
    logic          x_rd_en;
    logic [DW-1:0] y_out;
    logic          y_out_full;
    logic          y_wr_en;

    interp_fir #(
        .DATA_WIDTH   (DW),
        .TAPS         (TAPS),
        .INTERPOLATION(L),
        .BITS         (BITS),
        .COEFF        (C)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .x_in      (x_in),
        .x_empty   (x_empty),
        .x_rd_en   (x_rd_en),
        .y_out     (y_out),
        .y_out_full(y_out_full),
        .y_wr_en   (y_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            ph;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] src_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] hist[M];
    int            edge_cnt = 0;
    int            pop_edge = 0;
    bit            bp_since_pop = 1'b1;
    bit            full_at_edge = 1'b0;
    bit            rst_at_edge = 1'b1;
    int            out_cnt = 0;
    logic [DW-1:0] last_y = '0;
    bit            starve = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: output phase p = wrapped sum over taps of
    // (h[k*L+p] * x[n-k]) >>> BITS, each term truncated to DW bits
    function automatic logic [DW-1:0] ref_out(int p);
        logic [DW-1:0] s;
        longint        pr;
        s = '0;
        for (int k = 0; k < M; k++) begin
            pr = longint'($signed(C[k*L+p])) * longint'($signed(hist[k]));
            pr = pr >>> BITS;
            s  = s + pr[DW-1:0];
        end
`ifdef INTERP_FIR_GAIN_EN
        s = s << $clog2(L);
`endif
        return s;
    endfunction

    // Upstream FIFO head presentation
    always @(negedge clk) begin
        x_empty = starve || (src_q.size() == 0);
        x_in    = (src_q.size() > 0) ? src_q[0] : 32'hDEAD_BEEF;
    end

    // FIFO/stimulus side: just before each rising edge, observe pops and predict
    initial begin
        for (int i = 0; i < M; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                exp_q.delete();
                for (int i = 0; i < M; i++) hist[i] = '0;
                rst_at_edge = 1'b1;
                check("rd_en_in_reset", 64'(x_rd_en), 64'd0);
            end else begin
                rst_at_edge = 1'b0;
                if (x_empty) check("rd_en_when_empty", 64'(x_rd_en), 64'd0);
                if (x_rd_en) begin
                    check("pop_before_all_phases", 64'(exp_q.size()), 64'd0);
                    for (int i = M - 1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = x_in;
                    if (src_q.size() > 0) void'(src_q.pop_front());
                    for (int p = 0; p < L; p++) exp_q.push_back('{d: ref_out(p), ph: p});
                    pop_edge     = edge_cnt + 1;
                    bp_since_pop = 1'b0;
                end
            end
            full_at_edge = y_out_full;
            if (y_out_full) bp_since_pop = 1'b1;
        end
    end

    // Monitor: after each rising edge compare whatever the DUT presents
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            if (rst_at_edge) begin
                check("reset_y_out", 64'(y_out), 64'd0);
                check("reset_y_wr_en", 64'(y_wr_en), 64'd0);
                last_y = '0;
            end else if (y_wr_en) begin
                check("write_while_full", 64'(full_at_edge), 64'd0);
                check("spurious_write", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("y_out_phase%0d", e.ph), 64'(y_out), 64'(e.d));
                    if (e.ph == 0 && !bp_since_pop)
                        check("pop_to_write_latency", 64'(edge_cnt - pop_edge), 64'd5);
                end
                last_y = y_out;
                out_cnt++;
            end else begin
                check("y_out_hold", 64'(y_out), 64'(last_y));
            end
        end
    end

    task automatic wait_outputs(input int tgt, input string nm);
        int t;
        t = 0;
        while (out_cnt < tgt && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check(nm, 64'(out_cnt >= tgt), 64'd1);
    endtask

    initial begin
        int tgt;
        reset      = 1'b1;
        x_empty    = 1'b1;
        x_in       = '0;
        y_out_full = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Impulse response: outputs walk through the prototype coefficients
        tgt = out_cnt + 32;
        src_q.push_back(32'd1024);
        repeat (3) src_q.push_back(32'd0);
        wait_outputs(tgt, "impulse_done");

        // DC input settles to per-phase coefficient sums
        tgt = out_cnt + 64;
        repeat (8) src_q.push_back(32'd1024);
        wait_outputs(tgt, "dc_done");

        // Backpressure held for 10 cycles while a write is pending
        tgt = out_cnt + 32;
        repeat (4) src_q.push_back($urandom);
        repeat (7) @(negedge clk);
        y_out_full = 1'b1;
        repeat (10) @(negedge clk);
        y_out_full = 1'b0;
        wait_outputs(tgt, "backpressure_done");

        // Starvation: nothing available, outputs must hold
        repeat (20) @(negedge clk);

        // Random data with random backpressure and starvation
        tgt = out_cnt + 24 * L;
        repeat (24) src_q.push_back($urandom);
        for (int t = 0; t < 6000 && out_cnt < tgt; t++) begin
            @(negedge clk);
            y_out_full = ($urandom_range(0, 3) == 0);
            starve     = ($urandom_range(0, 7) == 0);
        end
        y_out_full = 1'b0;
        starve     = 1'b0;
        wait_outputs(tgt, "random_done");

        // Reset during phase 3 accumulation, then a repeated impulse
        tgt = out_cnt + 3;
        src_q.push_back(32'd1024);
        repeat (3) src_q.push_back(32'd0);
        wait_outputs(tgt, "pre_reset_phases");
        @(negedge clk);
        reset = 1'b1;
        src_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tgt = out_cnt + 32;
        src_q.push_back(32'd1024);
        repeat (3) src_q.push_back(32'd0);
        wait_outputs(tgt, "impulse_after_reset");

        repeat (10) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
